serial_master_port: RTL and testbench

//  Initiator end of the bit-serial system bus. Takes parallel read/write requests from a local client,

---
 rtl/serial_master_port.sv | 174 +++++++++++++++++
 tb/tb_serial_master_port.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_master_port.sv
// Bit-serial bus initiator: shifts address then write data MSB-first on wr_bus,
// and for reads collects DATA_WIDTH bits from rd_bus into a parallel response.
//   state  | meaning
//   S_IDLE | waiting for a client request, req_ready high
//   S_ADDR | shifting address bits out on wr_bus
//   S_DATA | shifting write-data bits out on wr_bus
//   S_RD   | collecting read-data bits from rd_bus
//   S_DONE | one-cycle response pulse
module serial_master_port #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  wr_bus,
    output logic                  mode,
    output logic                  master_valid,
    output logic                  master_ready,
    input  logic                  rd_bus,
    input  logic                  slave_ready,
    input  logic                  slave_valid
);

    localparam int SW   = ADDR_WIDTH + DATA_WIDTH;
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] TO_LAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RD,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         sr_q, sr_d;
    logic                  mode_q, mode_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         to_q, to_d;
    logic [DATA_WIDTH-2:0] rdsr_q, rdsr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] rd_shift;
    logic                  bit_hs;
    logic                  busy;

    // Read word as it would look with the current rd_bus bit shifted in.
    assign rd_shift  = {rdsr_q, rd_bus};
    assign rsp_rdata = rdata_q;
    assign mode      = mode_q;

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        to_d         = to_q;
        rdsr_d       = rdsr_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready    = 1'b0;
        master_valid = 1'b0;
        master_ready = 1'b0;
        wr_bus       = 1'b0;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        bit_hs       = 1'b0;
        busy         = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    sr_d    = {req_addr, req_wdata};
                    mode_d  = req_wr;
                    cnt_d   = '0;
                    to_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR, S_DATA: begin
                busy         = 1'b1;
                master_valid = 1'b1;
                wr_bus       = sr_q[SW-1];
                bit_hs       = slave_ready;
                if (bit_hs) begin
                    sr_d  = {sr_q[SW-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    to_d  = '0;
                    if (state_q == S_ADDR && cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = mode_q ? S_DATA : S_RD;
                    end else if (state_q == S_DATA && cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_RD: begin
                busy         = 1'b1;
                master_ready = 1'b1;
                bit_hs       = slave_valid;
                if (bit_hs) begin
                    rdsr_d = rd_shift[DATA_WIDTH-2:0];
                    cnt_d  = cnt_q + CW'(1);
                    to_d   = '0;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        rdata_d = rd_shift;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stall watchdog: any cycle without a bit handshake counts toward abort.
        if (TIMEOUT > 0 && busy && !bit_hs) begin
            to_d = to_q + TW'(1);
            if (to_q == TO_LAST) begin
                state_d = S_DONE;
                err_d   = 1'b1;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            to_q    <= '0;
            rdsr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            rdsr_q  <= rdsr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_serial_master_port.sv
// Randomised slave behaviour checked cycle by cycle against a transaction-level
// model: expected bit stream, handshake counts and the stall watchdog rule.
module tb_serial_master_port;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          wr_bus;
    logic          mode;
    logic          master_valid;
    logic          master_ready;
    logic          rd_bus = 1'b0;
    logic          slave_ready = 1'b0;
    logic          slave_valid = 1'b0;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] model_rdata = '0;

    serial_master_port #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .wr_bus      (wr_bus),
        .mode        (mode),
        .master_valid(master_valid),
        .master_ready(master_ready),
        .rd_bus      (rd_bus),
        .slave_ready (slave_ready),
        .slave_valid (slave_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave handshake pattern: 0 always, 1 every other cycle, 2 random, 3 never, 4 from 2nd cycle.
    function automatic logic pat_bit(input int pat, input int c);
        case (pat)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            2:       return 1'($urandom_range(0, 1));
            3:       return 1'b0;
            4:       return c != 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] rdata, input int rdy_pat, input int vld_pat,
                           input int rst_after, input logic hold, input logic hwr,
                           input logic [AW-1:0] haddr, input logic [DW-1:0] hdata);
        logic [AW+DW-1:0] vec;
        int               nwr, ntot, nbits, run, c;
        logic             done, err, phase_wr, hs;
        vec   = {addr, wdata};
        nwr   = wr ? AW + DW : AW;
        ntot  = wr ? AW + DW : AW + DW;
        nbits = 0;
        run   = 0;
        c     = 0;
        done  = 1'b0;
        err   = 1'b0;

        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        if (hold) begin
            req_wr    = hwr;
            req_addr  = haddr;
            req_wdata = hdata;
        end else begin
            req_valid = 1'b0;
            req_wr    = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
        end

        while (!done) begin
            phase_wr = nbits < nwr;
            chk("rsp_valid_busy", rsp_valid, 0);
            chk("master_valid", master_valid, phase_wr);
            chk("master_ready", master_ready, !phase_wr);
            chk("req_ready_busy", req_ready, 0);
            chk("mode", mode, wr);
            chk("wr_bus", wr_bus, phase_wr ? vec[AW+DW-1-nbits] : 1'b0);
            chk("rsp_rdata_hold", rsp_rdata, model_rdata);
            if (phase_wr) begin
                slave_ready = pat_bit(rdy_pat, c);
                slave_valid = 1'($urandom_range(0, 1));
                rd_bus      = 1'($urandom_range(0, 1));
                hs          = slave_ready;
            end else begin
                slave_valid = pat_bit(vld_pat, c);
                slave_ready = 1'($urandom_range(0, 1));
                rd_bus      = slave_valid ? rdata[DW-1-(nbits-nwr)] : 1'($urandom_range(0, 1));
                hs          = slave_valid;
            end
            if (hs) begin
                nbits++;
                run = 0;
            end else begin
                run++;
            end
            if (nbits == ntot) done = 1'b1;
            else if (run == TO) begin
                done = 1'b1;
                err  = 1'b1;
            end
            @(posedge clk); #1;
            c++;
            if (rst_after > 0 && hs && nbits == rst_after) begin
                rstn        = 1'b0;
                slave_ready = 1'b0;
                slave_valid = 1'b0;
                @(posedge clk); #1;
                rstn        = 1'b1;
                model_rdata = '0;
                chk("rst_master_valid", master_valid, 0);
                chk("rst_master_ready", master_ready, 0);
                chk("rst_mode", mode, 0);
                chk("rst_req_ready", req_ready, 1);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_wr_bus", wr_bus, 0);
                chk("rst_rsp_rdata", rsp_rdata, model_rdata);
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    chk("rst_no_rsp", rsp_valid, 0);
                end
                return;
            end
            if (c > 600) begin
                chk("cycle_budget", c, 600);
                return;
            end
        end

        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, err);
        if (!wr && !err) model_rdata = rdata;
        chk("rsp_rdata", rsp_rdata, model_rdata);
        chk("rsp_master_valid", master_valid, 0);
        chk("rsp_master_ready", master_ready, 0);
        chk("rsp_req_ready", req_ready, 0);
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_master_valid", master_valid, 0);
    endtask

    logic          rw;
    logic [AW-1:0] ra;
    logic [DW-1:0] rwd, rrd;

    initial begin
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("reset_master_valid", master_valid, 0);
        chk("reset_master_ready", master_ready, 0);
        chk("reset_wr_bus", wr_bus, 0);
        chk("reset_mode", mode, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b1, 16'h0005, 8'hA5, 8'h00, 4, 0, 0, 1'b0, 1'b0, '0, '0);
        run_txn(1'b0, 16'h0012, 8'h3C, 8'hA5, 0, 1, 0, 1'b0, 1'b0, '0, '0);
        run_txn(1'b1, 16'h0005, 8'hA5, 8'h00, 1, 0, 0, 1'b0, 1'b0, '0, '0);
        run_txn(1'b1, 16'hBEEF, 8'h5A, 8'h00, 3, 0, 0, 1'b0, 1'b0, '0, '0);
        run_txn(1'b0, 16'h7001, 8'h00, 8'hC3, 0, 3, 0, 1'b0, 1'b0, '0, '0);
        run_txn(1'b1, 16'h1234, 8'h99, 8'h00, 0, 0, 10, 1'b0, 1'b0, '0, '0);
        run_txn(1'b1, 16'h8001, 8'h7E, 8'h00, 2, 0, 0, 1'b0, 1'b0, '0, '0);
        run_txn(1'b1, 16'h4321, 8'h0F, 8'h00, 2, 0, 0, 1'b1, 1'b0, 16'hA0A0, 8'h11);
        run_txn(1'b0, 16'hA0A0, 8'h11, 8'h6D, 0, 2, 0, 1'b0, 1'b0, '0, '0);

        for (int i = 0; i < 24; i++) begin
            rw  = 1'($urandom_range(0, 1));
            ra  = AW'($urandom);
            rwd = DW'($urandom);
            rrd = DW'($urandom);
            run_txn(rw, ra, rwd, rrd, $urandom_range(0, 2), $urandom_range(0, 2), 0,
                    1'b0, 1'b0, '0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
